instr_fetch_unit: RTL and testbench

Instruction fetch/issue sequencer placed directly upstream of the multicycle processor. It reads 16-bit words from a synchronous-read program ROM and presents each instruction on the processor's `DIN` with a one-cycle `Run` pulse. It prefetches the immediate word of `mvi` so the immediate is on `DIN` the cycle after `Run`, then waits for the processor's `Done` before fetching the next instruction. It also traps a HALT opcode locally and counts retired instructions.

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch/issue sequencer feeding a multicycle processor from a
//               synchronous-read ROM, with mvi immediate prefetch and HALT trap.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int         ADDR_W  = 5,
  parameter logic [2:0] HALT_OP = 3'b111,
  parameter logic [2:0] MVI_OP  = 3'b001
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Enable,
  input  logic [15:0]       MemData,
  input  logic              Done,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic              Halted,
  output logic [15:0]       RetiredCount
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FETCH       = 3'd1,
    S_DECODE      = 3'd2,
    S_IMM_FETCH   = 3'd3,
    S_IMM_CAPTURE = 3'd4,
    S_ISSUE       = 3'd5,
    S_WAIT_DONE   = 3'd6,
    S_HALT        = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [15:0]         r_ir;
  logic [15:0]         r_imm;
  logic                r_is_mvi;
  logic [15:0]         r_din;
  logic                r_halted;
  logic [15:0]         r_retired;
  logic [2:0]          w_opcode;

  assign w_opcode = MemData[15:13];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:        if (Enable) w_next_state = S_FETCH;
      S_FETCH:       w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_opcode == HALT_OP)     w_next_state = S_HALT;
        else if (w_opcode == MVI_OP) w_next_state = S_IMM_FETCH;
        else                         w_next_state = S_ISSUE;
      end
      S_IMM_FETCH:   w_next_state = S_IMM_CAPTURE;
      S_IMM_CAPTURE: w_next_state = S_ISSUE;
      S_ISSUE:       w_next_state = S_WAIT_DONE;
      S_WAIT_DONE:   if (Done) w_next_state = Enable ? S_FETCH : S_IDLE;
      S_HALT:        w_next_state = S_HALT;
      default:       w_next_state = S_IDLE;
    endcase
  end

  // Datapath: DIN is only ever loaded entering ISSUE (instruction) or
  // entering WAIT_DONE for mvi (immediate); every other state holds it.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pc      <= '0;
      r_ir      <= 16'h0000;
      r_imm     <= 16'h0000;
      r_is_mvi  <= 1'b0;
      r_din     <= 16'h0000;
      r_halted  <= 1'b0;
      r_retired <= 16'h0000;
    end else begin
      case (r_state)
        S_DECODE: begin
          r_ir     <= MemData;
          r_is_mvi <= (w_opcode == MVI_OP);
          if (w_opcode == HALT_OP) begin
            r_halted <= 1'b1;
          end else begin
            r_pc <= r_pc + ADDR_W'(1);
            if (w_opcode != MVI_OP) r_din <= MemData;
          end
        end
        S_IMM_CAPTURE: begin
          r_imm <= MemData;
          r_pc  <= r_pc + ADDR_W'(1);
          r_din <= r_ir;
        end
        S_ISSUE: begin
          if (r_is_mvi) r_din <= r_imm;
        end
        S_WAIT_DONE: begin
          if (Done && (r_retired != 16'hFFFF)) r_retired <= r_retired + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Run decodes straight from the state register so reset clears it at once.
  assign Run          = (r_state == S_ISSUE);
  assign MemAddr      = r_pc;
  assign DIN          = r_din;
  assign Halted       = r_halted;
  assign RetiredCount = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit (vector table plus
//               directed multi-cycle sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Enable = 1'b0;
  logic        Done = 1'b0;
  logic [15:0] MemData;
  logic [4:0]  MemAddr;
  logic [15:0] DIN;
  logic        Run;
  logic        Halted;
  logic [15:0] RetiredCount;

  logic [15:0] rom [32];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        en;
    logic        done;
    logic        run;
    logic [15:0] din;
    logic [4:0]  addr;
    logic        halted;
    logic [15:0] retired;
  } vec_t;

  vec_t vecs[$];

  instr_fetch_unit #(.ADDR_W(5), .HALT_OP(3'b111), .MVI_OP(3'b001)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Enable      (Enable),
    .MemData     (MemData),
    .Done        (Done),
    .MemAddr     (MemAddr),
    .DIN         (DIN),
    .Run         (Run),
    .Halted      (Halted),
    .RetiredCount(RetiredCount)
  );

  always #5 Clock = ~Clock;

  // synchronous-read ROM
  always @(posedge Clock) MemData <= rom[MemAddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic run, input logic [15:0] din,
                         input logic [4:0] addr, input logic halted, input logic [15:0] ret);
    chk({tag, ".Run"}, {31'd0, Run}, {31'd0, run});
    chk({tag, ".DIN"}, {16'd0, DIN}, {16'd0, din});
    chk({tag, ".MemAddr"}, {27'd0, MemAddr}, {27'd0, addr});
    chk({tag, ".Halted"}, {31'd0, Halted}, {31'd0, halted});
    chk({tag, ".RetiredCount"}, {16'd0, RetiredCount}, {16'd0, ret});
  endtask

  task automatic add(input logic en, input logic done, input logic run, input logic [15:0] din,
                     input logic [4:0] addr, input logic halted, input logic [15:0] ret);
    vec_t v;
    v.en = en; v.done = done; v.run = run; v.din = din;
    v.addr = addr; v.halted = halted; v.retired = ret;
    vecs.push_back(v);
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clock);
      chk_all($sformatf("%s[%0d]", tag, i), vecs[i].run, vecs[i].din,
              vecs[i].addr, vecs[i].halted, vecs[i].retired);
      Enable = vecs[i].en;
      Done   = vecs[i].done;
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    Enable = 1'b0;
    Done   = 1'b0;
    @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    chk_all("reset", 1'b0, 16'h0000, 5'd0, 1'b0, 16'h0000);
    Resetn = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    @(negedge Clock);
    while (!Run && n < 40) begin
      @(negedge Clock);
      n++;
    end
    chk({tag, ".run_seen"}, {31'd0, Run}, 32'd1);
  endtask

  task automatic pulse_done();
    @(negedge Clock);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
  endtask

  initial begin
    clear_rom();

    // Ordinary instruction then HALT; Done also driven in IDLE, DECODE, ISSUE, HALT
    rom[0] = 16'h4200;
    rom[1] = 16'hE000;
    do_reset();
    add(0, 1, 0, 16'h0000, 5'd0, 0, 16'd0);   // IDLE, Enable low, Done ignored
    add(1, 1, 0, 16'h0000, 5'd0, 0, 16'd0);   // IDLE, Enable sampled
    add(1, 0, 0, 16'h0000, 5'd0, 0, 16'd0);   // FETCH
    add(1, 1, 0, 16'h0000, 5'd0, 0, 16'd0);   // DECODE, Done ignored
    add(1, 1, 1, 16'h4200, 5'd1, 0, 16'd0);   // ISSUE, Done ignored
    add(1, 1, 0, 16'h4200, 5'd1, 0, 16'd0);   // WAIT_DONE, Done taken
    add(1, 0, 0, 16'h4200, 5'd1, 0, 16'd1);   // FETCH addr 1
    add(1, 0, 0, 16'h4200, 5'd1, 0, 16'd1);   // DECODE HALT
    add(1, 1, 0, 16'h4200, 5'd1, 1, 16'd1);   // HALT
    add(1, 0, 0, 16'h4200, 5'd1, 1, 16'd1);
    add(1, 0, 0, 16'h4200, 5'd1, 1, 16'd1);
    run_vectors("add_halt");

    // mvi with immediate, then HALT at address 2
    clear_rom();
    rom[0] = 16'h2400;
    rom[1] = 16'h00A5;
    rom[2] = 16'hE000;
    do_reset();
    add(1, 0, 0, 16'h0000, 5'd0, 0, 16'd0);   // IDLE
    add(1, 0, 0, 16'h0000, 5'd0, 0, 16'd0);   // FETCH
    add(1, 0, 0, 16'h0000, 5'd0, 0, 16'd0);   // DECODE mvi
    add(1, 0, 0, 16'h0000, 5'd1, 0, 16'd0);   // IMM_FETCH
    add(1, 0, 0, 16'h0000, 5'd1, 0, 16'd0);   // IMM_CAPTURE
    add(1, 0, 1, 16'h2400, 5'd2, 0, 16'd0);   // ISSUE
    add(1, 0, 0, 16'h00A5, 5'd2, 0, 16'd0);   // WAIT_DONE
    add(1, 1, 0, 16'h00A5, 5'd2, 0, 16'd0);   // WAIT_DONE, Done
    add(1, 0, 0, 16'h00A5, 5'd2, 0, 16'd1);   // FETCH addr 2
    add(1, 0, 0, 16'h00A5, 5'd2, 0, 16'd1);   // DECODE HALT
    add(1, 0, 0, 16'h00A5, 5'd2, 1, 16'd1);   // HALT
    run_vectors("mvi");

    // PC wrap: 31 one-word instructions, mvi at 31 takes immediate from 0
    clear_rom();
    rom[0]  = 16'h1234;
    rom[31] = 16'h2400;
    do_reset();
    Enable = 1'b1;
    for (int k = 0; k < 31; k++) begin
      wait_run($sformatf("wrap_nop%0d", k));
      chk($sformatf("wrap_nop%0d.DIN", k), {16'd0, DIN}, {16'd0, rom[k]});
      pulse_done();
    end
    wait_run("wrap_mvi");
    chk("wrap_mvi.DIN_instr", {16'd0, DIN}, 32'h2400);
    chk("wrap_mvi.MemAddr", {27'd0, MemAddr}, 32'd1);
    @(negedge Clock);
    chk("wrap_mvi.DIN_imm", {16'd0, DIN}, 32'h1234);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    chk("wrap_next.MemAddr", {27'd0, MemAddr}, 32'd1);
    chk("wrap_next.RetiredCount", {16'd0, RetiredCount}, 32'd32);

    // Enable dropped during WAIT_DONE: finish, idle with PC held, resume
    clear_rom();
    rom[0] = 16'h4200;
    rom[1] = 16'h4600;
    rom[2] = 16'hE000;
    do_reset();
    Enable = 1'b1;
    wait_run("en_drop_first");
    @(negedge Clock);
    Enable = 1'b0;
    repeat (3) @(negedge Clock);
    chk_all("en_drop_waiting", 1'b0, 16'h4200, 5'd1, 1'b0, 16'd0);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    repeat (4) @(negedge Clock);
    chk_all("en_drop_idle", 1'b0, 16'h4200, 5'd1, 1'b0, 16'd1);
    Enable = 1'b1;
    wait_run("en_drop_resume");
    chk("en_drop_resume.DIN", {16'd0, DIN}, 32'h4600);
    chk("en_drop_resume.MemAddr", {27'd0, MemAddr}, 32'd2);

    // Reset mid-mvi in WAIT_DONE: immediate clear, refetch from address 0
    clear_rom();
    rom[0] = 16'h2400;
    rom[1] = 16'h00A5;
    rom[2] = 16'hE000;
    do_reset();
    Enable = 1'b1;
    wait_run("rst_mvi");
    @(negedge Clock);
    chk("rst_mvi.DIN_imm", {16'd0, DIN}, 32'h00A5);
    #2 Resetn = 1'b0;
    #1 chk_all("rst_async", 1'b0, 16'h0000, 5'd0, 1'b0, 16'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    wait_run("rst_refetch");
    chk("rst_refetch.DIN", {16'd0, DIN}, 32'h2400);
    chk("rst_refetch.MemAddr", {27'd0, MemAddr}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
